// File: rtl/mem_boot_loader.sv
// mem_boot_loader
//   Heap initialiser between the boot ROM, the heap RAM and the evaluator core.
//   After reset it copies IMAGE_WORDS words from ROM into RAM[0..IMAGE_WORDS-1],
//   writes FILL_VALUE (NIL) to RAM[IMAGE_WORDS..MEM_WORDS-1], raises boot_done
//   and then passes core memory traffic straight through to the RAM.
//
//   Optional feature macro: BOOT_VERIFY_EN
//     defined   : after the fill, re-read the image from ROM and RAM and compare.
//                 A mismatch parks the block in ERROR (boot_error=1) and keeps
//                 the index of the first bad word in err_idx_q.
//     undefined : no verify pass, boot_error is tied low.
//
// Ports
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   rom_addr     : boot ROM word address (registered)
//   rom_data     : ROM read data, valid one cycle after rom_addr
//   ram_addr/ram_we/ram_wdata : heap RAM write/read port
//   ram_rdata    : RAM read data, valid one cycle after ram_addr
//   core_addr/core_we/core_wdata : core memory request, honoured only in DONE
//   core_rdata   : RAM read data to the core, zero until boot_done
//   boot_done    : heap initialised, held until reset
//   boot_error   : verify mismatch
module mem_boot_loader #(
    parameter int                    ADDR_WIDTH  = 16,
    parameter int                    DATA_WIDTH  = 16,
    parameter int                    IMAGE_WORDS = 256,
    parameter int                    MEM_WORDS   = 1024,
    parameter logic [DATA_WIDTH-1:0] FILL_VALUE  = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    input  logic                  core_we,
    input  logic [DATA_WIDTH-1:0] core_wdata,
    output logic [DATA_WIDTH-1:0] core_rdata,
    output logic                  boot_done,
    output logic                  boot_error
);

    // One extra counter bit so MEM_WORDS == 2**ADDR_WIDTH still has an
    // end value distinct from zero.
    localparam int                  CW        = ADDR_WIDTH + 1;
    localparam logic [CW-1:0]       IMG_LAST  = CW'(IMAGE_WORDS - 1);
    localparam logic [CW-1:0]       IMG_END   = CW'(IMAGE_WORDS);
    localparam logic [CW-1:0]       MEM_END   = CW'(MEM_WORDS);
    localparam bit                  NO_FILL   = (IMAGE_WORDS == MEM_WORDS);

    typedef enum logic [2:0] {
        COPY  = 3'd0,
        FILL  = 3'd1,
        DONE  = 3'd2,
        ERROR = 3'd3
`ifdef BOOT_VERIFY_EN
        , VERIFY = 3'd4
`endif
    } state_t;

`ifdef BOOT_VERIFY_EN
    localparam state_t            AFTER_FILL = VERIFY;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(IMAGE_WORDS - 1);
`else
    localparam state_t            AFTER_FILL = DONE;
`endif

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d, cnt_inc;
    logic [ADDR_WIDTH-1:0]   rom_addr_q, rom_addr_d;
    // Registered write stage: address/strobe one cycle behind the issue
    // counter so the write lines up with the ROM read latency.
    logic                    wr_vld_q, wr_vld_d;
    logic                    wr_rom_q, wr_rom_d;
    logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic                    in_done;
    logic                    drain;

`ifdef BOOT_VERIFY_EN
    logic                    cmp_vld_q, cmp_vld_d;
    logic [ADDR_WIDTH-1:0]   cmp_idx_q, cmp_idx_d;
    logic [ADDR_WIDTH-1:0]   err_idx_q, err_idx_d;   // first failing word
`endif

    assign cnt_inc = cnt_q + CW'(1);

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= COPY;
            cnt_q      <= '0;
            rom_addr_q <= '0;
            wr_vld_q   <= 1'b0;
            wr_rom_q   <= 1'b0;
            wr_addr_q  <= '0;
`ifdef BOOT_VERIFY_EN
            cmp_vld_q  <= 1'b0;
            cmp_idx_q  <= '0;
            err_idx_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rom_addr_q <= rom_addr_d;
            wr_vld_q   <= wr_vld_d;
            wr_rom_q   <= wr_rom_d;
            wr_addr_q  <= wr_addr_d;
`ifdef BOOT_VERIFY_EN
            cmp_vld_q  <= cmp_vld_d;
            cmp_idx_q  <= cmp_idx_d;
            err_idx_q  <= err_idx_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rom_addr_d = rom_addr_q;
        wr_vld_d   = 1'b0;
        wr_rom_d   = 1'b0;
        wr_addr_d  = wr_addr_q;
`ifdef BOOT_VERIFY_EN
        cmp_vld_d  = 1'b0;
        cmp_idx_d  = cmp_idx_q;
        err_idx_d  = err_idx_q;
`endif

        case (state_q)
            COPY: begin
                if (cnt_q < IMG_END) begin
                    wr_vld_d  = 1'b1;
                    wr_rom_d  = 1'b1;
                    wr_addr_d = cnt_q[ADDR_WIDTH-1:0];
                    cnt_d     = cnt_inc;
                    // rom_addr freezes on the last image word
                    if (cnt_q != IMG_LAST) begin
                        rom_addr_d = cnt_inc[ADDR_WIDTH-1:0];
                    end else if (!NO_FILL) begin
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                if (cnt_q < MEM_END) begin
                    wr_vld_d  = 1'b1;
                    wr_addr_d = cnt_q[ADDR_WIDTH-1:0];
                    cnt_d     = cnt_inc;
                end
            end
`ifdef BOOT_VERIFY_EN
            VERIFY: begin
                // Issue side: j on rom_addr/ram_addr, compare one cycle later
                if (cnt_q < IMG_END) begin
                    cmp_vld_d = 1'b1;
                    cmp_idx_d = cnt_q[ADDR_WIDTH-1:0];
                    cnt_d     = cnt_inc;
                    if (cnt_q != IMG_LAST) begin
                        rom_addr_d = cnt_inc[ADDR_WIDTH-1:0];
                    end
                end
                if (cmp_vld_q) begin
                    if (rom_data != ram_rdata) begin
                        state_d   = ERROR;
                        err_idx_d = cmp_idx_q;
                    end else if (cmp_idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end
                end
            end
`endif
            DONE:    state_d = DONE;
            ERROR:   state_d = ERROR;
            default: state_d = COPY;
        endcase

        // Drain cycle: the final write is on the bus this cycle, nothing new
        // is issued, and the hand-over happens on the following edge. With
        // IMAGE_WORDS == MEM_WORDS this drain happens in COPY itself.
        drain = ((state_q == COPY) && (cnt_q == IMG_END)) ||
                ((state_q == FILL) && (cnt_q == MEM_END));
        if (drain) begin
            state_d = AFTER_FILL;
`ifdef BOOT_VERIFY_EN
            cnt_d      = '0;
            rom_addr_d = '0;
`endif
        end
    end

    // Outputs
    assign in_done   = (state_q == DONE);
    assign boot_done = in_done;
    assign rom_addr  = rom_addr_q;

`ifdef BOOT_VERIFY_EN
    assign boot_error = (state_q == ERROR);
    // During VERIFY the RAM read address tracks the ROM address
    assign ram_addr   = in_done ? core_addr :
                        (state_q == VERIFY) ? rom_addr_q : wr_addr_q;
`else
    assign boot_error = 1'b0;
    assign ram_addr   = in_done ? core_addr : wr_addr_q;
`endif

    // Copy data comes straight from the ROM output register; it lines up
    // with the write stage because both trail the issued address by a cycle.
    assign ram_we     = in_done ? core_we : wr_vld_q;
    assign ram_wdata  = in_done  ? core_wdata :
                        !wr_vld_q ? '0 :
                        wr_rom_q  ? rom_data : FILL_VALUE;
    assign core_rdata = in_done ? ram_rdata : '0;

endmodule
